aes_uart_host: RTL and testbench

AES_UART_HOST -- requirements
Module: aes_uart_host

---
 rtl/aes_uart_host.sv | 150 +++++++++++++++
 tb/tb_aes_uart_host.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_uart_host.sv
`default_nettype none
// ============================================================================
// Module  : aes_uart_host
// Brief   : Sends a 16-byte block over a byte UART, then collects a 16-byte reply.
// Revision: 1.0  initial release
// ============================================================================
module aes_uart_host #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         start,
  input  logic [0:127] blockIn,
  output logic         ready,
  output logic [0:127] blockOut,
  output logic         done,
  output logic         timeout,
  output logic         txBegin,
  output logic [0:7]   din,
  input  logic         txBusy,
  input  logic         rxRdy,
  input  logic [0:7]   dout,
  output logic         rxRdyClr
);

  localparam int c_cntWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cntWidth-1:0] c_cntLast = c_cntWidth'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX_WAIT  = 3'd1,
    TX_START = 3'd2,
    TX_ACK   = 3'd3,
    RX_WAIT  = 3'd4,
    RX_CLR   = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t                r_state;
  logic [3:0]            r_index;
  logic [c_cntWidth-1:0] r_count;
  logic [0:127]          r_txReg;
  logic [0:127]          r_rxBuf;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state  <= IDLE;
      r_index  <= '0;
      r_count  <= '0;
      r_txReg  <= '0;
      r_rxBuf  <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      timeout  <= 1'b0;
      txBegin  <= 1'b0;
      rxRdyClr <= 1'b0;
      din      <= '0;
      blockOut <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      txBegin <= 1'b0;
      case (r_state)
        IDLE: begin
          // Stray bytes are flushed here; a start takes precedence.
          rxRdyClr <= rxRdy & ~start;
          if (start) begin
            r_txReg <= blockIn;
            r_index <= '0;
            r_count <= '0;
            ready   <= 1'b0;
            r_state <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (!txBusy) begin
            din     <= r_txReg[{r_index, 3'b000} +: 8];
            txBegin <= 1'b1;
            r_state <= TX_START;
          end
        end
        TX_START: begin
          r_count <= '0;
          r_state <= TX_ACK;
        end
        TX_ACK: begin
          if (txBusy) begin
            if (r_index == 4'd15) begin
              r_index <= '0;
              r_count <= '0;
              r_state <= RX_WAIT;
            end else begin
              r_index <= r_index + 4'd1;
              r_state <= TX_WAIT;
            end
          end else if (r_count == c_cntLast) begin
            timeout <= 1'b1;
            ready   <= 1'b1;
            r_index <= '0;
            r_count <= '0;
            r_state <= IDLE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        RX_WAIT: begin
          if (rxRdy) begin
            r_rxBuf[{r_index, 3'b000} +: 8] <= dout;
            rxRdyClr <= 1'b1;
            r_state  <= RX_CLR;
          end else if (r_count == c_cntLast) begin
            // Abandon the reply; blockOut keeps the previous good block.
            timeout <= 1'b1;
            ready   <= 1'b1;
            r_index <= '0;
            r_count <= '0;
            r_state <= IDLE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        RX_CLR: begin
          if (!rxRdy) begin
            rxRdyClr <= 1'b0;
            r_count  <= '0;
            if (r_index == 4'd15) begin
              r_state <= DONE;
            end else begin
              r_index <= r_index + 4'd1;
              r_state <= RX_WAIT;
            end
          end
        end
        DONE: begin
          blockOut <= r_rxBuf;
          done     <= 1'b1;
          ready    <= 1'b1;
          r_index  <= '0;
          r_state  <= IDLE;
        end
        default: begin
          ready   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_uart_host.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_uart_host
// Brief   : Bench for aes_uart_host with a buffered loopback UART responder.
// Revision: 1.0  initial release
// ============================================================================
module tb_aes_uart_host;

  logic         clock = 1'b0;
  logic         resetN;
  logic         start;
  logic [0:127] blockIn;
  logic         ready;
  logic [0:127] blockOut;
  logic         done;
  logic         timeout;
  logic         txBegin;
  logic [0:7]   din;
  logic         txBusy;
  logic         rxRdy;
  logic [0:7]   dout;
  logic         rxRdyClr;

  int errors = 0;
  int checks = 0;

  bit         holdBusy = 1'b0;
  logic [7:0] txLog[$];
  logic [7:0] rxQueue[$];
  int         rxBudget = 0;
  logic [7:0] rxXor = 8'h00;

  aes_uart_host #(.TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .resetN(resetN), .start(start), .blockIn(blockIn),
    .ready(ready), .blockOut(blockOut), .done(done), .timeout(timeout),
    .txBegin(txBegin), .din(din), .txBusy(txBusy), .rxRdy(rxRdy),
    .dout(dout), .rxRdyClr(rxRdyClr)
  );

  always #5 clock = ~clock;

  // UART transmitter: logs each strobed byte and echoes it into the receive queue.
  initial begin
    txBusy = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (holdBusy) begin
        txBusy = 1'b1;
      end else if (txBegin) begin
        txLog.push_back(din);
        rxQueue.push_back(din);
        txBusy = 1'b1;
        repeat ($urandom_range(2, 6)) @(posedge clock);
        #1;
        txBusy = 1'b0;
      end else begin
        txBusy = 1'b0;
      end
    end
  end

  // UART receiver: presents queued bytes one at a time until cleared.
  initial begin
    int d;
    rxRdy = 1'b0;
    dout  = '0;
    forever begin
      @(posedge clock); #1;
      if (rxBudget > 0 && rxQueue.size() > 0) begin
        d = $urandom_range(0, 3);
        repeat (d) begin @(posedge clock); #1; end
        dout     = rxQueue.pop_front() ^ rxXor;
        rxRdy    = 1'b1;
        rxBudget = rxBudget - 1;
        for (int i = 0; i < 1000; i++) begin
          @(posedge clock); #1;
          if (rxRdyClr) break;
        end
        rxRdy = 1'b0;
      end
    end
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  function automatic logic [7:0] expByte(input logic [0:127] blk, input int k);
    logic [127:0] v;
    v = blk;
    v = v >> (8 * (15 - k));
    return v[7:0];
  endfunction

  function automatic bit txMatches(input logic [0:127] blk);
    if (txLog.size() != 16) return 1'b0;
    for (int k = 0; k < 16; k++)
      if (txLog[k] !== expByte(blk, k)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic pulseStart(input logic [0:127] blk);
    blockIn = blk;
    start   = 1'b1;
    @(posedge clock); #1;
    start   = 1'b0;
  endtask

  task automatic waitOutcome(input int limit, output bit gotDone, output bit gotTimeout);
    gotDone = 1'b0;
    gotTimeout = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clock); #1;
      if (done) gotDone = 1'b1;
      if (timeout) gotTimeout = 1'b1;
      if (gotDone || gotTimeout) break;
    end
  endtask

  task automatic runBlock(input logic [0:127] blk, input int rxCount,
                          output bit gotDone, output bit gotTimeout);
    txLog.delete();
    rxQueue.delete();
    rxBudget = rxCount;
    pulseStart(blk);
    waitOutcome(3000, gotDone, gotTimeout);
  endtask

  task automatic test_reset;
    resetN = 1'b0; start = 1'b0; blockIn = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({ready, done, timeout, txBegin, rxRdyClr} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready/done/timeout/txBegin/rxRdyClr=%b, required 10000",
               {ready, done, timeout, txBegin, rxRdyClr});
    end
    checks++;
    if (din !== 8'h00 || blockOut !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got din=%h blockOut=%h, required 0", din, blockOut);
    end
    resetN = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_loopback;
    logic [0:127] blk;
    bit gd, gt;
    blk = 128'h00112233445566778899aabbccddeeff;
    rxXor = 8'h00;
    runBlock(blk, 16, gd, gt);
    checks++;
    if (!(gd && !gt)) begin
      errors++;
      $display("FAIL loop_done: got done=%0b timeout=%0b, required done=1 timeout=0", gd, gt);
    end
    checks++;
    if (!txMatches(blk)) begin
      errors++;
      $display("FAIL loop_din_seq: got %0d bytes first=%h, required 16 bytes 00,11,..,ff",
               txLog.size(), (txLog.size() > 0) ? txLog[0] : 8'hxx);
    end
    checks++;
    if (blockOut !== blk) begin
      errors++;
      $display("FAIL loop_blockOut: got %h, required %h", blockOut, blk);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL loop_ready: got %b, required 1", ready);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL loop_done_width: got done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_random;
    logic [0:127] blk;
    bit gd, gt;
    for (int n = 0; n < 4; n++) begin
      blk   = {$urandom(), $urandom(), $urandom(), $urandom()};
      rxXor = 8'($urandom());
      runBlock(blk, 16, gd, gt);
      checks++;
      if (!gd || gt || !txMatches(blk)) begin
        errors++;
        $display("FAIL rand_tx[%0d]: got done=%0b timeout=%0b txOk=%0b, required 1 0 1",
                 n, gd, gt, txMatches(blk));
      end
      checks++;
      if (blockOut !== (blk ^ {16{rxXor}})) begin
        errors++;
        $display("FAIL rand_blockOut[%0d]: got %h, required %h", n, blockOut, blk ^ {16{rxXor}});
      end
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end
    rxXor = 8'h00;
  endtask

  task automatic test_start_while_busy;
    logic [0:127] blkA, blkB;
    bit gd, gt, seen;
    blkA = {$urandom(), $urandom(), $urandom(), $urandom()};
    blkB = ~blkA;
    txLog.delete(); rxQueue.delete(); rxBudget = 16;
    pulseStart(blkA);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (txLog.size() >= 3) begin seen = 1'b1; break; end
      @(posedge clock); #1;
    end
    checks++;
    if (!seen || ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready: got seen=%0b ready=%b, required seen=1 ready=0", seen, ready);
    end
    pulseStart(blkB);
    waitOutcome(3000, gd, gt);
    checks++;
    if (!gd || !txMatches(blkA)) begin
      errors++;
      $display("FAIL busy_ignore_tx: got done=%0b txOk=%0b, required done=1 txOk=1", gd, txMatches(blkA));
    end
    checks++;
    if (blockOut !== blkA) begin
      errors++;
      $display("FAIL busy_blockOut: got %h, required %h", blockOut, blkA);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_timeout;
    logic [0:127] blk, prev;
    bit reached, gd, gt, extra;
    int n;
    prev = blockOut;
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    txLog.delete(); rxQueue.delete(); rxBudget = 10;
    pulseStart(blk);
    reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rxBudget == 0 && rxRdy == 1'b0 && txLog.size() == 16) begin reached = 1'b1; break; end
      @(posedge clock); #1;
    end
    gd = 1'b0; gt = 1'b0; n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clock); #1;
      if (done) gd = 1'b1;
      if (timeout) begin gt = 1'b1; n = i; break; end
    end
    checks++;
    if (!reached || !gt || gd || n < 62 || n > 68) begin
      errors++;
      $display("FAIL timeout_pulse: got reached=%0b timeout=%0b done=%0b after %0d cycles, required timeout near 64 cycles, no done",
               reached, gt, gd, n);
    end
    checks++;
    if (blockOut !== prev || ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_state: got blockOut=%h ready=%b, required blockOut=%h ready=1", blockOut, ready, prev);
    end
    extra = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clock); #1;
      if (timeout || done) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL timeout_single: got further timeout/done pulses, required none");
    end
    rxQueue.delete();
  endtask

  task automatic test_idle_stray;
    bit sawClr, readyLow, pulse, finished;
    sawClr = 1'b0; readyLow = 1'b0; pulse = 1'b0; finished = 1'b0;
    rxQueue.delete();
    rxQueue.push_back(8'hA5);
    rxBudget = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (rxRdyClr) sawClr = 1'b1;
      if (!ready) readyLow = 1'b1;
      if (done || timeout) pulse = 1'b1;
      if (sawClr && rxBudget == 0 && !rxRdy) begin finished = 1'b1; break; end
    end
    @(posedge clock); #1;
    checks++;
    if (!finished || !sawClr) begin
      errors++;
      $display("FAIL stray_clr: got finished=%0b rxRdyClr seen=%0b, required 1 1", finished, sawClr);
    end
    checks++;
    if (rxRdyClr !== 1'b0 || readyLow || pulse || ready !== 1'b1) begin
      errors++;
      $display("FAIL stray_state: got rxRdyClr=%b readyLow=%0b pulse=%0b ready=%b, required 0 0 0 1",
               rxRdyClr, readyLow, pulse, ready);
    end
  endtask

  task automatic test_hold_busy;
    logic [0:127] blk;
    bit early, gd, gt;
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    holdBusy = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    txLog.delete(); rxQueue.delete(); rxBudget = 16;
    pulseStart(blk);
    early = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clock); #1;
      if (txBegin) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL hold_txBegin: got txBegin=1 while txBusy held, required 0");
    end
    holdBusy = 1'b0;
    waitOutcome(3000, gd, gt);
    checks++;
    if (!gd || gt || !txMatches(blk) || blockOut !== blk) begin
      errors++;
      $display("FAIL hold_complete: got done=%0b timeout=%0b txOk=%0b blockOut=%h, required 1 0 1 %h",
               gd, gt, txMatches(blk), blockOut, blk);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid;
    logic [0:127] blk;
    bit reached, pulse, gd, gt;
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    txLog.delete(); rxQueue.delete(); rxBudget = 8;
    pulseStart(blk);
    reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rxBudget == 0 && rxRdy == 1'b0 && txLog.size() == 16) begin reached = 1'b1; break; end
      @(posedge clock); #1;
    end
    repeat (2) @(posedge clock);
    #1;
    resetN = 1'b0;
    #1;
    checks++;
    if (!reached || {ready, done, timeout, txBegin, rxRdyClr} !== 5'b10000 ||
        din !== 8'h00 || blockOut !== 128'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got reached=%0b ctrl=%b din=%h blockOut=%h, required 1 10000 00 0",
               reached, {ready, done, timeout, txBegin, rxRdyClr}, din, blockOut);
    end
    rxQueue.delete();
    pulse = 1'b0;
    repeat (3) begin @(posedge clock); #1; if (done || timeout) pulse = 1'b1; end
    resetN = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (done || timeout) pulse = 1'b1;
    end
    checks++;
    if (pulse || blockOut !== 128'h0) begin
      errors++;
      $display("FAIL midreset_quiet: got pulse=%0b blockOut=%h, required no pulse and blockOut 0", pulse, blockOut);
    end
    runBlock(blk, 16, gd, gt);
    checks++;
    if (!gd || gt || blockOut !== blk) begin
      errors++;
      $display("FAIL midreset_recover: got done=%0b timeout=%0b blockOut=%h, required 1 0 %h",
               gd, gt, blockOut, blk);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_random();
    test_start_while_busy();
    test_timeout();
    test_idle_stray();
    test_hold_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
